// File: rtl/sd_step_trace.sv
// Passive trace tap for a srdy/drdy link: every completed transfer is stored with a
// timestamp in a circular buffer and drained through a srdy/drdy read port.
// Optional capture trigger: define SD_STEP_TRACE_TRIG_EN.
module sd_step_trace #(
    parameter int width = 32,
    parameter int depth = 16,
    parameter int tsw = 16,
    localparam int asz = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tap_srdy,
    input  logic             tap_drdy,
    input  logic [width-1:0] tap_data,
    output logic             rd_srdy,
    input  logic             rd_drdy,
    output logic [width-1:0] rd_data,
    output logic [tsw-1:0]   rd_stamp,
    input  logic             cfg_clear,
    input  logic             cfg_wrap,
    output logic [asz:0]     sts_count,
`ifdef SD_STEP_TRACE_TRIG_EN
    input  logic [width-1:0] cfg_trig_mask,
    input  logic [width-1:0] cfg_trig_value,
    output logic             sts_armed,
`endif
    output logic             sts_overflow
);

    localparam logic [asz:0] full_count = (asz+1)'(depth);

    // Handshake: a transfer completes on a rising clk edge where srdy && drdy are both 1.
    // The tap only observes its link; on the read port rd_srdy holds an entry until rd_drdy
    // accepts it, and the entry stays stable meanwhile unless wrap-on-full moves the head.

    logic [tsw-1:0]       ts;
    logic [asz-1:0]       wr_ptr;
    logic [asz-1:0]       rd_ptr;
    logic [asz:0]         count;
    logic                 overflow;
    logic [tsw+width-1:0] mem [depth];
    logic [tsw+width-1:0] rd_entry;

    logic xfer;
    logic armed_now;
    logic cap;
    logic pop;
    logic full;
    logic wr_en;
    logic rd_adv;

    assign xfer = tap_srdy && tap_drdy;

`ifdef SD_STEP_TRACE_TRIG_EN
    logic armed;
    logic trig_hit;

    assign trig_hit  = xfer && ((tap_data & cfg_trig_mask) == (cfg_trig_value & cfg_trig_mask));
    // The triggering transfer itself is captured, so the match is OR-ed in combinationally.
    assign armed_now = armed || trig_hit;
    assign sts_armed = armed;

    always_ff @(posedge clk) begin
        if (rst || cfg_clear) begin
            armed <= 1'b0;
        end else if (trig_hit) begin
            armed <= 1'b1;
        end
    end
`else
    assign armed_now = 1'b1;
`endif

    assign cap     = xfer && armed_now;
    assign rd_srdy = (count != '0);
    assign pop     = rd_srdy && rd_drdy;
    assign full    = (count == full_count);

    // When full, wr_ptr == rd_ptr: a write either replaces the entry being popped this
    // cycle, or (wrap mode) overwrites the oldest entry and drags the head forward.
    assign wr_en  = cap && (!full || pop || cfg_wrap);
    assign rd_adv = pop || (cap && full && cfg_wrap);

    always_ff @(posedge clk) begin
        if (rst || cfg_clear) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + tsw'(1);
            if (wr_en) begin
                wr_ptr <= wr_ptr + asz'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + asz'(1);
            end
            if (wr_en && !rd_adv) begin
                count <= count + (asz+1)'(1);
            end else if (rd_adv && !wr_en) begin
                count <= count - (asz+1)'(1);
            end
            if (cap && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !cfg_clear && wr_en) begin
            mem[wr_ptr] <= {ts, tap_data};
        end
    end

    assign rd_entry     = mem[rd_ptr];
    assign rd_data      = rd_entry[width-1:0];
    assign rd_stamp     = rd_entry[tsw+width-1:width];
    assign sts_count    = count;
    assign sts_overflow = overflow;

endmodule

// File: tb/tb_sd_step_trace.sv
// Directed bench for sd_step_trace: a cycle table for the basic capture path, then
// hand-written sequences for full/wrap/clear corners, drained against an expected queue.
module tb_sd_step_trace;

    localparam int width = 32;
    localparam int depth = 16;
    localparam int tsw = 16;
    localparam int asz = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             tap_srdy;
    logic             tap_drdy;
    logic [width-1:0] tap_data;
    logic             rd_srdy;
    logic             rd_drdy;
    logic [width-1:0] rd_data;
    logic [tsw-1:0]   rd_stamp;
    logic             cfg_clear;
    logic             cfg_wrap;
    logic [asz:0]     sts_count;
    logic             sts_overflow;
`ifdef SD_STEP_TRACE_TRIG_EN
    logic [width-1:0] cfg_trig_mask;
    logic [width-1:0] cfg_trig_value;
    logic             sts_armed;
`endif

    sd_step_trace #(.width(width), .depth(depth), .tsw(tsw)) dut (
        .clk(clk),
        .rst(rst),
        .tap_srdy(tap_srdy),
        .tap_drdy(tap_drdy),
        .tap_data(tap_data),
        .rd_srdy(rd_srdy),
        .rd_drdy(rd_drdy),
        .rd_data(rd_data),
        .rd_stamp(rd_stamp),
        .cfg_clear(cfg_clear),
        .cfg_wrap(cfg_wrap),
        .sts_count(sts_count),
`ifdef SD_STEP_TRACE_TRIG_EN
        .cfg_trig_mask(cfg_trig_mask),
        .cfg_trig_value(cfg_trig_value),
        .sts_armed(sts_armed),
`endif
        .sts_overflow(sts_overflow)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int tb_cyc = 0;  // timestamp value a capture driven now would record
    logic [tsw+width-1:0] exp_q[$];

    typedef struct {
        logic             tap_s;
        logic             tap_d;
        logic [width-1:0] data;
        logic             exp_srdy;
        logic [asz:0]     exp_count;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tap_srdy = 1'b0;
        tap_drdy = 1'b0;
        tap_data = '0;
        rd_drdy = 1'b0;
        cfg_clear = 1'b0;
        cfg_wrap = 1'b0;
`ifdef SD_STEP_TRACE_TRIG_EN
        cfg_trig_mask = '0;
        cfg_trig_value = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tb_cyc = 0;
        exp_q.delete();
    endtask

    // Driver: one completed transfer on the tapped link, optionally with a read-port pop.
    task automatic drive_xfer(input logic [width-1:0] d, input logic pop_too);
        tap_srdy = 1'b1;
        tap_drdy = 1'b1;
        tap_data = d;
        rd_drdy = pop_too;
        tick();
        tap_srdy = 1'b0;
        tap_drdy = 1'b0;
        rd_drdy = 1'b0;
    endtask

    // Scoreboard drain: one pop per cycle, bounded by the expected queue.
    task automatic drain(input string name);
        logic [tsw+width-1:0] e;
        logic ok;
        ok = 1'b1;
        while (ok && exp_q.size() > 0) begin
            e = exp_q[0];
            chk({name, "_srdy"}, 64'(rd_srdy), 64'd1);
            if (!rd_srdy) begin
                ok = 1'b0;
            end else begin
                chk({name, "_data"}, 64'(rd_data), 64'(e[width-1:0]));
                chk({name, "_stamp"}, 64'(rd_stamp), 64'(e[tsw+width-1:width]));
                rd_drdy = 1'b1;
                tick();
                rd_drdy = 1'b0;
                void'(exp_q.pop_front());
            end
        end
        exp_q.delete();
        chk({name, "_empty"}, 64'(rd_srdy), 64'd0);
    endtask

    initial begin
        // c: tap_s tap_d data  exp_srdy exp_count (outputs seen at start of cycle c)
        tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 5'd0};
        tbl[1]  = '{1'b1, 1'b0, 32'hEE, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'hEE, 1'b0, 5'd0};
        tbl[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 5'd0};
        tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 5'd0};
        tbl[5]  = '{1'b1, 1'b1, 32'hA1, 1'b0, 5'd0};
        tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 5'd1};
        tbl[7]  = '{1'b1, 1'b1, 32'hA2, 1'b1, 5'd1};
        tbl[8]  = '{1'b1, 1'b1, 32'hA3, 1'b1, 5'd2};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 5'd3};
        tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 5'd3};

        // Reset state and basic capture timing
        do_reset();
        chk("rst_srdy", 64'(rd_srdy), 64'd0);
        chk("rst_count", 64'(sts_count), 64'd0);
        chk("rst_ovf", 64'(sts_overflow), 64'd0);
`ifdef SD_STEP_TRACE_TRIG_EN
        chk("rst_armed", 64'(sts_armed), 64'd0);
        cfg_trig_mask = '0;
`endif
        for (int c = 0; c < 11; c++) begin
            chk($sformatf("t1_srdy_c%0d", c), 64'(rd_srdy), 64'(tbl[c].exp_srdy));
            chk($sformatf("t1_count_c%0d", c), 64'(sts_count), 64'(tbl[c].exp_count));
            tap_srdy = tbl[c].tap_s;
            tap_drdy = tbl[c].tap_d;
            tap_data = tbl[c].data;
            tick();
        end
        tap_srdy = 1'b0;
        tap_drdy = 1'b0;
        exp_q.push_back({16'd5, 32'hA1});
        exp_q.push_back({16'd7, 32'hA2});
        exp_q.push_back({16'd8, 32'hA3});
        drain("t1");
        chk("t1_count_end", 64'(sts_count), 64'd0);

        // Full, stop mode: 18 captures keep the first 16
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i < depth) exp_q.push_back({tsw'(tb_cyc), width'(i)});
            drive_xfer(width'(i), 1'b0);
            if (i == depth - 1) begin
                chk("t2_count_at_full", 64'(sts_count), 64'd16);
                chk("t2_ovf_at_full", 64'(sts_overflow), 64'd0);
            end
        end
        chk("t2_count", 64'(sts_count), 64'd16);
        chk("t2_ovf", 64'(sts_overflow), 64'd1);
        drain("t2");

        // Full, wrap mode: 18 captures keep the last 16
        do_reset();
        cfg_wrap = 1'b1;
        for (int i = 0; i < 18; i++) begin
            exp_q.push_back({tsw'(tb_cyc), width'(i)});
            if (exp_q.size() > depth) void'(exp_q.pop_front());
            drive_xfer(width'(i), 1'b0);
        end
        chk("t3_count", 64'(sts_count), 64'd16);
        chk("t3_ovf", 64'(sts_overflow), 64'd1);
        chk("t3_head", 64'(rd_data), 64'd2);
        drain("t3");

        // Full, stop mode, capture and pop together
        do_reset();
        for (int i = 0; i < depth; i++) begin
            exp_q.push_back({tsw'(tb_cyc), 32'h100 + width'(i)});
            drive_xfer(32'h100 + width'(i), 1'b0);
        end
        chk("t4_head", 64'(rd_data), 64'h100);
        void'(exp_q.pop_front());
        exp_q.push_back({tsw'(tb_cyc), 32'h99});
        drive_xfer(32'h99, 1'b1);
        chk("t4_count", 64'(sts_count), 64'd16);
        chk("t4_ovf", 64'(sts_overflow), 64'd0);
        drain("t4");

        // Not full, capture and pop together
        do_reset();
        exp_q.push_back({tsw'(tb_cyc), 32'h10});
        drive_xfer(32'h10, 1'b0);
        exp_q.push_back({tsw'(tb_cyc), 32'h11});
        drive_xfer(32'h11, 1'b0);
        chk("t6_head", 64'(rd_data), 64'h10);
        void'(exp_q.pop_front());
        exp_q.push_back({tsw'(tb_cyc), 32'h12});
        drive_xfer(32'h12, 1'b1);
        chk("t6_count", 64'(sts_count), 64'd2);
        drain("t6");

        // Clear wins over a simultaneous capture and pop
        do_reset();
        for (int i = 0; i < 17; i++) drive_xfer(width'(i), 1'b0);
        chk("t5_ovf_before", 64'(sts_overflow), 64'd1);
        cfg_clear = 1'b1;
        drive_xfer(32'hEE, 1'b1);
        cfg_clear = 1'b0;
        tb_cyc = 0;
        chk("t5_srdy", 64'(rd_srdy), 64'd0);
        chk("t5_count", 64'(sts_count), 64'd0);
        chk("t5_ovf", 64'(sts_overflow), 64'd0);
        exp_q.push_back({16'd0, 32'h77});
        drive_xfer(32'h77, 1'b0);
        chk("t5_count_after", 64'(sts_count), 64'd1);
        drain("t5");

`ifdef SD_STEP_TRACE_TRIG_EN
        // Trigger: only 0x57 onward is captured
        do_reset();
        cfg_trig_mask = 32'hF0;
        cfg_trig_value = 32'h50;
        drive_xfer(32'h31, 1'b0);
        drive_xfer(32'h42, 1'b0);
        chk("t7_armed_pre", 64'(sts_armed), 64'd0);
        chk("t7_count_pre", 64'(sts_count), 64'd0);
        exp_q.push_back({tsw'(tb_cyc), 32'h57});
        drive_xfer(32'h57, 1'b0);
        chk("t7_armed", 64'(sts_armed), 64'd1);
        exp_q.push_back({tsw'(tb_cyc), 32'h60});
        drive_xfer(32'h60, 1'b0);
        chk("t7_count", 64'(sts_count), 64'd2);
        drain("t7");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
